pc_next_unit: RTL and testbench

//  Program-counter register plus next-PC selection for the MIPS fetch stage.

---
 rtl/pc_next_unit_pkg.sv | 30 +++
 rtl/pc_next_unit_if.sv | 38 +++
 rtl/pc_target_sel.sv | 49 ++++
 rtl/pc_next_unit.sv | 127 ++++++++++++
 tb/tb_pc_next_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_next_unit_pkg.sv
// Shared types for the fetch-stage next-PC unit.
// Holds the FSM state encoding and the next-PC source-select codes.
// Imported by the target selector and the top level.
package pc_next_unit_pkg;

  localparam int PC_W_DEF = 32;

  // Fetch state: BOOT is a single settling cycle after reset.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  // Where the next PC comes from when running.
  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_EXC  = 3'd4,
    SEL_HOLD = 3'd5
  } sel_e;

  // True for the control-flow sources whose target must be word aligned.
  function automatic logic is_redirect(sel_e s);
    return (s == SEL_BR) || (s == SEL_J) || (s == SEL_JR);
  endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Fetch-control bundle between decode/execute and the next-PC unit.
// Master drives redirect/stall/exception requests, slave returns the fetch PC.
// Purely a wiring container, no logic.
interface pc_next_unit_if #(
  parameter int PC_W = 32
);

  logic            i_stall;
  logic            i_branch_taken;
  logic [PC_W-1:0] i_branch_target;
  logic            i_jump;
  logic [PC_W-1:0] i_jump_target;
  logic            i_jr;
  logic [PC_W-1:0] i_jr_target;
  logic            i_exception;
  logic [PC_W-1:0] i_exc_pc;
  logic            i_halt;
  logic            i_resume;
  logic [PC_W-1:0] o_pc;
  logic [PC_W-1:0] o_pc_inc;
  logic            o_valid;
  logic            o_flush;
  logic            o_misaligned;
  logic [PC_W-1:0] o_epc;

  modport master (
    output i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target,
           i_jr, i_jr_target, i_exception, i_exc_pc, i_halt, i_resume,
    input  o_pc, o_pc_inc, o_valid, o_flush, o_misaligned, o_epc
  );

  modport slave (
    input  i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target,
           i_jr, i_jr_target, i_exception, i_exc_pc, i_halt, i_resume,
    output o_pc, o_pc_inc, o_valid, o_flush, o_misaligned, o_epc
  );

endinterface

// File: rtl/pc_target_sel.sv
// Priority encoder and target mux for the next fetch PC.
// Purely combinational: exception > stall > jr > jump > branch > sequential.
// Flags a taken control-flow target whose low two bits are non-zero.
module pc_target_sel
  import pc_next_unit_pkg::*;
#(
  parameter int              PC_W    = PC_W_DEF,
  parameter logic [PC_W-1:0] EXC_VEC = PC_W'(32'h80)
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] pc_inc_i,
  input  logic            stall_i,
  input  logic            exception_i,
  input  logic            jr_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic [PC_W-1:0] jr_target_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic [PC_W-1:0] branch_target_i,
  output sel_e            sel_o,
  output logic [PC_W-1:0] target_o,
  output logic            misaligned_o
);

  // Pick the winning source and its target address.
  always_comb begin
    sel_o    = SEL_SEQ;
    target_o = pc_inc_i;
    if (exception_i) begin
      sel_o    = SEL_EXC;
      target_o = EXC_VEC;
    end else if (stall_i) begin
      sel_o    = SEL_HOLD;
      target_o = pc_i;
    end else if (jr_i) begin
      sel_o    = SEL_JR;
      target_o = jr_target_i;
    end else if (jump_i) begin
      sel_o    = SEL_J;
      target_o = jump_target_i;
    end else if (branch_i) begin
      sel_o    = SEL_BR;
      target_o = branch_target_i;
    end
  end

  assign misaligned_o = is_redirect(sel_o) && (target_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC register, next-PC selection, halt FSM, EPC capture and squash pulses.
// Latency: any redirect reaches o_pc one clock after it is presented.
// Stall holds the PC (exception still wins); halt parks fetch until resume/exception.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h80),
  parameter int              INC       = 4
) (
  input  logic         clk,
  input  logic         rst,
  pc_next_unit_if.slave bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;

  logic [PC_W-1:0] pc_inc;
  sel_e            sel;
  logic [PC_W-1:0] sel_target;
  logic            sel_mis;

  assign pc_inc = pc_q + PC_W'(INC);

  pc_target_sel #(
    .PC_W    (PC_W),
    .EXC_VEC (EXC_VEC)
  ) u_sel (
    .pc_i            (pc_q),
    .pc_inc_i        (pc_inc),
    .stall_i         (bus.i_stall),
    .exception_i     (bus.i_exception),
    .jr_i            (bus.i_jr),
    .jump_i          (bus.i_jump),
    .branch_i        (bus.i_branch_taken),
    .jr_target_i     (bus.i_jr_target),
    .jump_target_i   (bus.i_jump_target),
    .branch_target_i (bus.i_branch_target),
    .sel_o           (sel),
    .target_o        (sel_target),
    .misaligned_o    (sel_mis)
  );

  // Next-state, next-PC and pulse generation; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      S_BOOT: begin
        // Inputs are ignored while settling; the boot vector itself is never fetched.
        state_d = S_RUN;
        pc_d    = pc_inc;
      end
      S_HALT: begin
        if (bus.i_exception) begin
          state_d = S_RUN;
          pc_d    = EXC_VEC;
          epc_d   = bus.i_exc_pc;
          flush_d = 1'b1;
        end else if (bus.i_resume) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        case (sel)
          SEL_EXC: begin
            pc_d    = EXC_VEC;
            epc_d   = bus.i_exc_pc;
            flush_d = 1'b1;
          end
          SEL_BR, SEL_J, SEL_JR: begin
            flush_d = 1'b1;
            if (sel_mis) begin
              // The faulting fetch is the one that issued the bad transfer.
              pc_d  = EXC_VEC;
              epc_d = pc_q;
              mis_d = 1'b1;
            end else begin
              pc_d = sel_target;
            end
          end
          SEL_HOLD: begin
            if (bus.i_halt) state_d = S_HALT;
          end
          default: begin
            if (bus.i_halt) state_d = S_HALT;
            else            pc_d    = sel_target;
          end
        endcase
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State, PC, EPC and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.o_pc         = pc_q;
  assign bus.o_pc_inc     = pc_inc;
  assign bus.o_valid      = (state_q == S_RUN);
  assign bus.o_flush      = flush_q;
  assign bus.o_misaligned = mis_q;
  assign bus.o_epc        = epc_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for the next-PC unit: directed scenarios then randomized traffic.
// Stimulus pushes expected post-edge state into a queue; a monitor pops and compares.
// Reference model tracks PC/EPC/boot/halt with plain arithmetic.
module tb_pc_next_unit;

  typedef struct {
    bit          rst, stall, br, j, jr, exc, halt, resume;
    logic [31:0] bt, jt, rt, ep;
  } stim_t;

  typedef struct {
    logic [31:0] pc, epc;
    bit          valid, flush, mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_next_unit_if #(.PC_W(32)) bus();

  pc_next_unit #(
    .PC_W      (32),
    .RESET_VEC (32'h0),
    .EXC_VEC   (32'h80),
    .INC       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t expq[$];

  // Reference model state
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_epc = 32'h0;
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Advance the model by one clock edge given the inputs of that cycle.
  task automatic model_step(input stim_t s, output exp_t e);
    logic [31:0] t;
    bit          fl, mi;
    fl = 1'b0;
    mi = 1'b0;
    if (s.rst) begin
      m_pc = 32'h0; m_epc = 32'h0; m_boot = 1'b1; m_halt = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_pc   = m_pc + 32'd4;
    end else if (m_halt) begin
      if (s.exc) begin
        m_halt = 1'b0; m_epc = s.ep; m_pc = 32'h80; fl = 1'b1;
      end else if (s.resume) begin
        m_halt = 1'b0;
      end
    end else if (s.exc) begin
      m_epc = s.ep; m_pc = 32'h80; fl = 1'b1;
    end else if (s.stall) begin
      if (s.halt) m_halt = 1'b1;
    end else if (s.jr || s.j || s.br) begin
      t  = s.jr ? s.rt : (s.j ? s.jt : s.bt);
      fl = 1'b1;
      if (t % 4 != 0) begin
        m_epc = m_pc; m_pc = 32'h80; mi = 1'b1;
      end else begin
        m_pc = t;
      end
    end else if (s.halt) begin
      m_halt = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc    = m_pc;
    e.epc   = m_epc;
    e.valid = !m_boot && !m_halt;
    e.flush = fl;
    e.mis   = mi;
  endtask

  // Apply one cycle of stimulus away from the active edge and queue its expectation.
  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst                 = s.rst;
    bus.i_stall         = s.stall;
    bus.i_branch_taken  = s.br;
    bus.i_branch_target = s.bt;
    bus.i_jump          = s.j;
    bus.i_jump_target   = s.jt;
    bus.i_jr            = s.jr;
    bus.i_jr_target     = s.rt;
    bus.i_exception     = s.exc;
    bus.i_exc_pc        = s.ep;
    bus.i_halt          = s.halt;
    bus.i_resume        = s.resume;
    model_step(s, e);
    expq.push_back(e);
  endtask

  task automatic jump_to(input logic [31:0] a);
    stim_t s;
    s = idle(); s.j = 1'b1; s.jt = a;
    drive(s);
  endtask

  // Monitor: compare every cycle for which an expectation is outstanding.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("o_pc",         bus.o_pc,                  e.pc);
        chk("o_pc_inc",     bus.o_pc_inc,              e.pc + 32'd4);
        chk("o_valid",      {31'b0, bus.o_valid},      {31'b0, e.valid});
        chk("o_flush",      {31'b0, bus.o_flush},      {31'b0, e.flush});
        chk("o_misaligned", {31'b0, bus.o_misaligned}, {31'b0, e.mis});
        chk("o_epc",        bus.o_epc,                 e.epc);
      end
    end
  end

  initial begin
    stim_t s;
    bus.i_stall = 0; bus.i_branch_taken = 0; bus.i_branch_target = 0;
    bus.i_jump = 0; bus.i_jump_target = 0; bus.i_jr = 0; bus.i_jr_target = 0;
    bus.i_exception = 0; bus.i_exc_pc = 0; bus.i_halt = 0; bus.i_resume = 0;

    // Reset two cycles, boot, then sequential fetch 4, 8, 12, 16
    s = idle(); s.rst = 1'b1;
    drive(s); drive(s);
    for (int i = 0; i < 40 && m_pc != 32'h10; i++) drive(idle());

    // Jump beats branch at PC 0x10
    s = idle(); s.br = 1'b1; s.bt = 32'h40; s.j = 1'b1; s.jt = 32'h100;
    drive(s);
    drive(idle());

    // Stall with a pending branch holds PC, then exception wins
    jump_to(32'h20);
    s = idle(); s.stall = 1'b1; s.br = 1'b1; s.bt = 32'h40;
    repeat (3) drive(s);
    s = idle(); s.exc = 1'b1; s.ep = 32'h1234_5678;
    drive(s);

    // Exception overrides a simultaneous stall
    s = idle(); s.exc = 1'b1; s.stall = 1'b1; s.ep = 32'h0000_0abc;
    drive(s);

    // Misaligned register-jump target
    jump_to(32'h200);
    s = idle(); s.jr = 1'b1; s.rt = 32'h102;
    drive(s);
    drive(idle());

    // Halt at 0x30, hold, resume, then reset while halted
    jump_to(32'h30);
    s = idle(); s.halt = 1'b1;
    drive(s);
    repeat (5) drive(idle());
    s = idle(); s.resume = 1'b1;
    drive(s);
    drive(idle());
    s = idle(); s.halt = 1'b1;
    drive(s);
    s = idle(); s.rst = 1'b1;
    drive(s);
    drive(idle());
    drive(idle());

    // Exception while halted
    s = idle(); s.halt = 1'b1;
    drive(s);
    s = idle(); s.exc = 1'b1; s.ep = 32'hdead_beec;
    drive(s);

    // Wrap from the top of the address space
    jump_to(32'hFFFF_FFFC);
    drive(idle());
    drive(idle());

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      s        = idle();
      s.rst    = ($urandom_range(0, 79) == 0);
      s.exc    = ($urandom_range(0, 15) == 0);
      s.stall  = ($urandom_range(0, 4) == 0);
      s.br     = ($urandom_range(0, 5) == 0);
      s.j      = ($urandom_range(0, 5) == 0);
      s.jr     = ($urandom_range(0, 5) == 0);
      s.halt   = ($urandom_range(0, 19) == 0);
      s.resume = ($urandom_range(0, 3) == 0);
      s.bt     = $urandom & ~32'h3;
      s.jt     = $urandom & ~32'h3;
      s.rt     = $urandom & ~32'h3;
      s.ep     = $urandom;
      if ($urandom_range(0, 7) == 0) s.bt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) s.jt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) s.rt[1:0] = 2'($urandom_range(1, 3));
      drive(s);
    end

    // Let the monitor drain, then confirm nothing was left unchecked
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
